// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 raster constants for the VGA timing block.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Total length of one axis (visible + porches + sync).
    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster output bundle: pixel coordinates, blanking, syncs and frame markers.
interface vga_timing_if;
    import vga_timing_pkg::*;

    coord_t      DrawX;
    coord_t      DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        frame_start;
    logic [7:0]  frame_cnt;

    modport master (
        output DrawX, DrawY, blank, hs, vs, frame_start, frame_cnt
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs, frame_start, frame_cnt
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus active/sync decode of the
// next position, so the parent can register those decodes in step with the counter.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF,
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t cnt,
    output logic   wrap,
    output logic   active_nxt,
    output logic   sync_nxt_n
);

    localparam int     TOTAL    = total(ACTIVE, FP, SYNC, BP);
    localparam coord_t LAST     = coord_t'(TOTAL - 1);
    localparam coord_t ACT_END  = coord_t'(ACTIVE);
    localparam coord_t SYNC_BEG = coord_t'(ACTIVE + FP);
    localparam coord_t SYNC_END = coord_t'(ACTIVE + FP + SYNC);

    coord_t cnt_q;
    coord_t cnt_d;

    // Next position and its decode.
    always_comb begin
        wrap  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 10'd1;
        end
        active_nxt = (cnt_d < ACT_END);
        sync_nxt_n = !((cnt_d >= SYNC_BEG) && (cnt_d < SYNC_END));
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing source: H/V counters, blanking, active-low syncs, frame markers.
// Optional feature macro: VGA_TIMING_SYNC_DLY_EN delays hs/vs by SYNC_DLY cycles
// to line up with renderers that have ROM-read plus output-register latency.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int SYNC_DLY = 2
) (
    input  logic         vga_clk,
    input  logic         reset_n,
    vga_timing_if.master vga
);

    if ((SYNC_DLY < 1) || (SYNC_DLY > 4)) begin : g_bad_sync_dly
        $error("SYNC_DLY must be in 1..4");
    end

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_wrap;
    logic   v_wrap;
    logic   h_act_nxt;
    logic   v_act_nxt;
    logic   h_sync_nxt_n;
    logic   v_sync_nxt_n;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP)
    ) u_h_axis (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en         (1'b1),
        .cnt        (h_cnt),
        .wrap       (h_wrap),
        .active_nxt (h_act_nxt),
        .sync_nxt_n (h_sync_nxt_n)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP)
    ) u_v_axis (
        .clk        (vga_clk),
        .rst_n      (reset_n),
        .en         (h_wrap),
        .cnt        (v_cnt),
        .wrap       (v_wrap),
        .active_nxt (v_act_nxt),
        .sync_nxt_n (v_sync_nxt_n)
    );

    logic       blank_q, blank_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Decode of the next pixel; a V wrap is exactly the (last,last)->(0,0) frame wrap.
    always_comb begin
        blank_d       = h_act_nxt & v_act_nxt;
        hs_d          = h_sync_nxt_n;
        vs_d          = v_sync_nxt_n;
        frame_start_d = v_wrap;
        frame_cnt_d   = frame_cnt_q + {7'd0, v_wrap};
    end

    // Registered raster outputs, aligned with the counter registers.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            blank_q       <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            blank_q       <= blank_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

`ifdef VGA_TIMING_SYNC_DLY_EN
    localparam int unsigned DLY_N = SYNC_DLY;

    logic [SYNC_DLY-1:0] hs_dly_q, hs_dly_d;
    logic [SYNC_DLY-1:0] vs_dly_q, vs_dly_d;

    // Shift the syncs one stage per cycle.
    always_comb begin
        hs_dly_d    = hs_dly_q;
        vs_dly_d    = vs_dly_q;
        hs_dly_d[0] = hs_q;
        vs_dly_d[0] = vs_q;
        for (int unsigned i = 1; i < DLY_N; i++) begin
            hs_dly_d[i] = hs_dly_q[i-1];
            vs_dly_d[i] = vs_dly_q[i-1];
        end
    end

    // Sync delay line, every stage idles inactive (high).
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            hs_dly_q <= '1;
            vs_dly_q <= '1;
        end else begin
            hs_dly_q <= hs_dly_d;
            vs_dly_q <= vs_dly_d;
        end
    end

    assign vga.hs = hs_dly_q[SYNC_DLY-1];
    assign vga.vs = vs_dly_q[SYNC_DLY-1];
`else
    assign vga.hs = hs_q;
    assign vga.vs = vs_q;
`endif

    assign vga.DrawX       = h_cnt;
    assign vga.DrawY       = v_cnt;
    assign vga.blank       = blank_q;
    assign vga.frame_start = frame_start_q;
    assign vga.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-mode instance for line timing and reset,
// and a shrunken-raster instance (15x10) for frame, wrap and 256-frame checks.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

`ifdef VGA_TIMING_SYNC_DLY_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    typedef struct {
        int x;
        int y;
        int blank;
        int hs;
        int vs;
        int fs;
        int fc;
    } obs_t;

    typedef struct {
        bit   rst_n;
        obs_t want;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    vga_timing_if ifa();
    vga_timing_if ifb();

    vga_timing_gen u_dut_a (
        .vga_clk (clk),
        .reset_n (rst_a),
        .vga     (ifa)
    );

    vga_timing_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (5),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (2),
        .SYNC_DLY (2)
    ) u_dut_b (
        .vga_clk (clk),
        .reset_n (rst_b),
        .vga     (ifb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Expected outputs after idx rising edges since the last reset (idx=0 is the reset state).
    function automatic obs_t model(input int idx, input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp);
        obs_t o;
        int ht, vt, s, sx, sy;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        o.x  = idx % ht;
        o.y  = (idx / ht) % vt;
        o.fc = (idx / (ht * vt)) % 256;
        o.fs    = (idx > 0 && o.x == 0 && o.y == 0) ? 1 : 0;
        o.blank = (idx > 0 && o.x < ha && o.y < va) ? 1 : 0;
        s = idx - DLY;
        if (s < 0) begin
            o.hs = 1;
            o.vs = 1;
        end else begin
            sx = s % ht;
            sy = (s / ht) % vt;
            o.hs = (sx >= ha + hfp && sx < ha + hfp + hsw) ? 0 : 1;
            o.vs = (sy >= va + vfp && sy < va + vfp + vsw) ? 0 : 1;
        end
        return o;
    endfunction

    function automatic obs_t model_a(input int idx);
        return model(idx, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t model_b(input int idx);
        return model(idx, 8, 2, 3, 2, 5, 1, 2, 2);
    endfunction

    function automatic obs_t get_a();
        obs_t o;
        o.x = int'(ifa.DrawX); o.y = int'(ifa.DrawY);
        o.blank = int'(ifa.blank); o.hs = int'(ifa.hs); o.vs = int'(ifa.vs);
        o.fs = int'(ifa.frame_start); o.fc = int'(ifa.frame_cnt);
        return o;
    endfunction

    function automatic obs_t get_b();
        obs_t o;
        o.x = int'(ifb.DrawX); o.y = int'(ifb.DrawY);
        o.blank = int'(ifb.blank); o.hs = int'(ifb.hs); o.vs = int'(ifb.vs);
        o.fs = int'(ifb.frame_start); o.fc = int'(ifb.frame_cnt);
        return o;
    endfunction

    task automatic check(input string name, input int act, input int want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        check({tag, ".DrawX"},       a.x,     e.x);
        check({tag, ".DrawY"},       a.y,     e.y);
        check({tag, ".blank"},       a.blank, e.blank);
        check({tag, ".hs"},          a.hs,    e.hs);
        check({tag, ".vs"},          a.vs,    e.vs);
        check({tag, ".frame_start"}, a.fs,    e.fs);
        check({tag, ".frame_cnt"},   a.fc,    e.fc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[9];
        obs_t o;
        int   hs_low, vs_low, fs_seen;

        // Reset held mid-line, then released: hand-computed raster values.
        for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, '{0, 0, 0, 1, 1, 0, 0}};
        tbl[5] = '{1'b1, '{1, 0, 1, 1, 1, 0, 0}};
        tbl[6] = '{1'b1, '{2, 0, 1, 1, 1, 0, 0}};
        tbl[7] = '{1'b1, '{3, 0, 1, 1, 1, 0, 0}};
        tbl[8] = '{1'b1, '{4, 0, 1, 1, 1, 0, 0}};

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) tick();
        cmp_obs("a_reset", get_a(), model_a(0));

        // Default mode: run to DrawX=300 on line 0.
        rst_a = 1'b1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            cmp_obs("a_run", get_a(), model_a(k));
        end
        check("a_pre_reset_x", int'(ifa.DrawX), 300);

        for (int i = 0; i < 9; i++) begin
            rst_a = tbl[i].rst_n;
            tick();
            cmp_obs($sformatf("a_vec%0d", i), get_a(), tbl[i].want);
        end

        // Two full lines after the reset: hs low for 96 cycles per line, DrawY steps at 799->0.
        hs_low = 0;
        for (int k = 5; k <= 1604; k++) begin
            tick();
            o = get_a();
            cmp_obs("a_line", o, model_a(k));
            if (o.hs == 0) hs_low++;
            if (k == 799) check("a_y_before_wrap", o.y, 0);
            if (k == 800) begin
                check("a_x_after_wrap", o.x, 0);
                check("a_y_after_wrap", o.y, 1);
            end
        end
        check("a_hs_low_cycles", hs_low, 192);

        // Small raster: run to (7,4), reset for 5 cycles mid-frame, release.
        rst_b = 1'b1;
        for (int k = 1; k <= 67; k++) begin
            tick();
            cmp_obs("b_run", get_b(), model_b(k));
        end
        check("b_pre_x", int'(ifb.DrawX), 7);
        check("b_pre_y", int'(ifb.DrawY), 4);
        rst_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp_obs("b_reset", get_b(), '{0, 0, 0, 1, 1, 0, 0});
        end
        rst_b = 1'b1;
        tick();
        cmp_obs("b_release", get_b(), '{1, 0, 1, 1, 1, 0, 0});

        // Three frames of per-cycle scoreboard.
        hs_low = 0;
        vs_low = 0;
        fs_seen = 0;
        for (int k = 2; k <= 450; k++) begin
            tick();
            o = get_b();
            cmp_obs("b_frame", o, model_b(k));
            if (o.hs == 0) hs_low++;
            if (o.vs == 0) vs_low++;
            if (o.fs == 1) fs_seen++;
            if (k == 149) check("b_fc_before_wrap", o.fc, 0);
            if (k == 150) begin
                check("b_fs_at_wrap", o.fs, 1);
                check("b_fc_at_wrap", o.fc, 1);
            end
            if (k == 151) check("b_fs_after_wrap", o.fs, 0);
        end
        check("b_fs_pulses_3f", fs_seen, 3);
        check("b_hs_low_cycles", hs_low, 90);
        check("b_vs_low_cycles", vs_low, 90);

        // Continue to 256 frames: frame_cnt wraps 255 -> 0.
        for (int k = 451; k <= 38401; k++) begin
            tick();
            o = get_b();
            if (o.fs == 1) fs_seen++;
            if (k == 38399) check("b_fc_255", o.fc, 255);
            if (k == 38400) begin
                check("b_fc_wrap0", o.fc, 0);
                check("b_fs_256", o.fs, 1);
                check("b_x_256", o.x, 0);
                check("b_y_256", o.y, 0);
            end
            if (k == 38401) begin
                check("b_fs_after_256", o.fs, 0);
                check("b_fc_after_256", o.fc, 0);
            end
        end
        check("b_fs_pulses_256f", fs_seen, 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
